mips_mmio_out: RTL
==================

Name: mips_mmio_out

Overview:
- Memory-mapped output peripheral on the mips_mem data bus, directly downstream of the CPU's memory interface.
- Captures CPU stores to a data address into a small FIFO and drains them to an external consumer over valid/ready.
- Exposes a status register to CPU loads so software can poll for space.
- Lets results (e.g. the Fibonacci value stored to 0xFF) leave the system without a bench peeking at internal nets.

Parameters:
- WIDTH, 8, data and address width (matches CPU WIDTH)
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2
- DATA_ADDR, 8'hFF, store here pushes writedata into the FIFO
- STAT_ADDR, 8'hFE, load returns status; store clears sticky flags

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- adr  in  WIDTH  CPU memory address
- writedata  in  WIDTH  CPU store data
- memwrite  in  1  CPU store strobe, one cycle per store
- memread  in  1  CPU load strobe (decode qualifier only)
- readdata  out  WIDTH  load data, combinational from adr
- sel  out  1  high when adr equals DATA_ADDR or STAT_ADDR; mips_mem muxes readdata on it and suppresses its RAM write
- out_data  out  WIDTH  FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle

Behaviour:
- Reset (clk edge with reset=1): read/write pointers, count, overflow and underflow-read flags all clear.
- Reset values: out_valid=0, out_data=0 (head entry zeroed), readdata=0 at non-selected addresses. Reset mid-stream discards all entries.
- Push: memwrite & adr==DATA_ADDR.
  - Not full: writedata enters the FIFO at the posedge.
  - Full and no pop in the same cycle: data dropped, sticky overflow set.
- Pop: out_valid & out_ready; head advances at the posedge.
- FIFO is first-word fall-through. A pushed word appears on out_data/out_valid the cycle after the push edge (latency 1).
- Simultaneous push+pop:
  - When full: both proceed, count unchanged, no overflow.
  - When empty: push proceeds; no pop because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Status read (adr==STAT_ADDR) returns {overflow, rd_empty_err, full, empty, count zero-extended} in bits 7:0 (bit7=overflow, bit6=rd_empty_err, bit5=full, bit4=empty, bits3:0=count). For WIDTH>8 the upper bits are 0.
- Load from DATA_ADDR returns the FIFO head without popping. If empty, it returns 0 and sets sticky rd_empty_err.
- Store to STAT_ADDR: writedata bit7=1 clears overflow, bit6=1 clears rd_empty_err. Other bits are ignored. A clear coincident with a new overflow event leaves overflow set (set wins).
- Stores and loads to other addresses have no effect; sel=0 and readdata=0.
- memread is used only to qualify rd_empty_err; readdata itself is a pure function of adr and state.

Optional Feature:
- Macro: MIPS_MMIO_LAST_EN.
- When defined: adds a register holding the last successfully pushed word (reset 0), readable at DATA_ADDR-2 (8'hFD). sel also covers that address.
- When undefined: 8'hFD is not decoded and falls through to RAM.

Decomposition:
- Shared package mips_mmio_pkg holds:
  - default address constants DATA_ADDR/STAT_ADDR/LAST_ADDR
  - status bit-index constants STAT_OVF=7, STAT_RDERR=6, STAT_FULL=5, STAT_EMPTY=4
  - a count-width function clog2
- Natural sub-module: mips_mmio_fifo, a generic FWFT sync FIFO (push/pop/full/empty/count).
- The top holds address decode, status register and sticky flags.

Test Plan:
- Reset held 4 cycles, then release → out_valid=0; load STAT_ADDR reads 8'h10 (empty, count 0).
- Stores 0x01, 0x02, 0x03 to 0xFF with out_ready=0 → status 8'h03; then out_ready=1 → out_data 01,02,03 on consecutive cycles, then out_valid=0.
- 5 stores with out_ready=0, DEPTH=4 → status 8'hA4 (ovf, full, count 4); fifth word absent from drain. Store 0x80 to 0xFE → status 8'h24.
- Full FIFO, out_ready=1 with simultaneous store 0x0D → count stays 4, no overflow, 0x0D drained last.
- Load 0xFF while empty → readdata 0, status bit6 set; store 0x40 to 0xFE clears it. Store 0x0D to 0xFF then reset mid-drain → out_valid=0 the next cycle.
- With MIPS_MMIO_LAST_EN: push 0x0D, drain it, load 0xFD → 0x0D. Without the macro: sel=0 at 0xFD.

Source files
------------

// File: rtl/mips_mmio_pkg.sv
// Shared constants and helpers for the mips_mmio_out peripheral.
// Holds the default bus addresses, the status bit positions and the clog2 helper.
package mips_mmio_pkg;

    localparam logic [7:0] DEF_DATA_ADDR = 8'hFF;
    localparam logic [7:0] DEF_STAT_ADDR = 8'hFE;
    localparam logic [7:0] DEF_LAST_ADDR = 8'hFD;

    localparam int STAT_OVF   = 7;
    localparam int STAT_RDERR = 6;
    localparam int STAT_FULL  = 5;
    localparam int STAT_EMPTY = 4;

    // Smallest r with 2**r >= n; used for pointer and count widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_mmio_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// The head is presented combinationally and reads as zero while empty, so a
// freshly reset FIFO drives zero on pop_data without clearing the storage.
module mips_mmio_fifo
    import mips_mmio_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CW   = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // proceeds when the head leaves in the same cycle.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mips_mmio_out.sv
// Memory-mapped output port on the mips_mem data bus.
// Stores to DATA_ADDR queue words for an external valid/ready consumer;
// STAT_ADDR exposes {overflow, read-empty error, full, empty, count}.
// Optional build macro MIPS_MMIO_LAST_EN adds a last-pushed-word register
// readable at DATA_ADDR-2.
module mips_mmio_out
    import mips_mmio_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] DATA_ADDR = WIDTH'(DEF_DATA_ADDR),
    parameter logic [WIDTH-1:0] STAT_ADDR = WIDTH'(DEF_STAT_ADDR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             memwrite,
    input  logic             memread,
    output logic [WIDTH-1:0] readdata,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = clog2(DEPTH) + 1;

    logic          hit_data;
    logic          hit_stat;
    logic          hit_last;
    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf_event;
    logic          rderr_event;
    logic          ovf_q, ovf_d;
    logic          rderr_q, rderr_d;
    logic [7:0]    status;
    logic [WIDTH-1:0] last_q;

    assign hit_data  = (adr == DATA_ADDR);
    assign hit_stat  = (adr == STAT_ADDR);
    assign push_req  = memwrite & hit_data;
    assign pop       = out_valid & out_ready;
    assign out_valid = ~fifo_empty;

    // A full FIFO drops the word unless the consumer frees a slot this cycle.
    assign ovf_event   = push_req & fifo_full & ~pop;
    assign rderr_event = memread & hit_data & fifo_empty;

    mips_mmio_fifo #(
        .W     (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (writedata),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef MIPS_MMIO_LAST_EN
    logic [WIDTH-1:0] last_d;
    logic             push_accept;

    assign hit_last    = (adr == WIDTH'(DEF_LAST_ADDR - DEF_DATA_ADDR) + DATA_ADDR);
    assign push_accept = push_req & (~fifo_full | pop);

    // Remember the most recent word that actually entered the FIFO.
    always_comb begin
        last_d = last_q;
        if (push_accept) begin
            last_d = writedata;
        end
    end

    // Last-pushed-word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign hit_last = 1'b0;
    assign last_q   = '0;
`endif

    // Sticky flags: software clears by writing 1s to STAT_ADDR, but a new
    // event in the same cycle keeps the flag set.
    always_comb begin
        ovf_d   = ovf_q;
        rderr_d = rderr_q;
        if (memwrite && hit_stat) begin
            if (writedata[STAT_OVF]) begin
                ovf_d = 1'b0;
            end
            if (writedata[STAT_RDERR]) begin
                rderr_d = 1'b0;
            end
        end
        if (ovf_event) begin
            ovf_d = 1'b1;
        end
        if (rderr_event) begin
            rderr_d = 1'b1;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            rderr_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            rderr_q <= rderr_d;
        end
    end

    // Status byte and load-data mux; readdata depends only on adr and state.
    always_comb begin
        status             = '0;
        status[STAT_OVF]   = ovf_q;
        status[STAT_RDERR] = rderr_q;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[3:0]        = 4'(fifo_count);
        readdata           = '0;
        if (hit_stat) begin
            readdata = WIDTH'(status);
        end else if (hit_data) begin
            readdata = out_data;
        end else if (hit_last) begin
            readdata = last_q;
        end
    end

    assign sel = hit_data | hit_stat | hit_last;

endmodule
